hpu_clint_mh: RTL and testbench

//  Multi-hart core-local interruptor; generalises the single-hart CLINT to HART_NUM harts.

---
 rtl/hpu_clint_mh.sv | 197 +++++++++++++++++++
 tb/tb_hpu_clint_mh.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpu_clint_mh.sv
// Multi-hart core-local interruptor: one shared prescaled mtime, per-hart mtimecmp/msip,
// and a 2-cycle register read path.
module hpu_clint_mh #(
    parameter int                  HART_NUM  = 4,
    parameter int                  DATA_WTH  = 32,
    parameter int                  ADDR_WTH  = 32,
    parameter logic [ADDR_WTH-1:0] BASE_ADDR = ADDR_WTH'('h0200_0000)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clk_rtc_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WTH-1:0]   waddr_i,
    input  logic [DATA_WTH-1:0]   wdata_i,
    input  logic [DATA_WTH/8-1:0] wstrb_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WTH-1:0]   raddr_i,
    output logic [DATA_WTH-1:0]   rdata_o,
    output logic                  rvalid_o,
    output logic [HART_NUM-1:0]   mtip_o,
    output logic [HART_NUM-1:0]   msip_o,
    output logic [63:0]           mtime_o
);

    localparam int STRB_WTH = DATA_WTH / 8;
    localparam int HART_W   = (HART_NUM > 1) ? $clog2(HART_NUM) : 1;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_CMP,
        SEL_CTRL,
        SEL_MTIME
    } sel_kind_e;

    typedef struct packed {
        sel_kind_e         kind;
        logic [HART_W-1:0] hart;
        logic              hi;
    } reg_sel_t;

    // Misaligned offsets and harts beyond HART_NUM decode to SEL_NONE.
    function automatic reg_sel_t decode(input logic [ADDR_WTH-1:0] addr);
        reg_sel_t            sel;
        logic [ADDR_WTH-1:0] off;
        sel.kind = SEL_NONE;
        sel.hart = '0;
        sel.hi   = 1'b0;
        off      = addr - BASE_ADDR;
        if (off[1:0] == 2'b00) begin
            if (off < ADDR_WTH'(4 * HART_NUM)) begin
                sel.kind = SEL_MSIP;
                sel.hart = off[HART_W+1:2];
            end else if (off >= ADDR_WTH'('h4000) &&
                         off <  ADDR_WTH'('h4000 + 8 * HART_NUM)) begin
                sel.kind = SEL_CMP;
                sel.hart = off[HART_W+2:3];
                sel.hi   = off[2];
            end else if (off == ADDR_WTH'('hBFF0)) begin
                sel.kind = SEL_CTRL;
            end else if (off == ADDR_WTH'('hBFF8)) begin
                sel.kind = SEL_MTIME;
            end else if (off == ADDR_WTH'('hBFFC)) begin
                sel.kind = SEL_MTIME;
                sel.hi   = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [DATA_WTH-1:0] merge_bytes(
        input logic [DATA_WTH-1:0] old_word,
        input logic [DATA_WTH-1:0] new_word,
        input logic [STRB_WTH-1:0] strb
    );
        logic [DATA_WTH-1:0] res;
        res = old_word;
        for (int b = 0; b < STRB_WTH; b++) begin
            if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

    logic [63:0]         mtime;
    logic [63:0]         mtimecmp [HART_NUM];
    logic [HART_NUM-1:0] msip;
    logic                ctrl_en;
    logic [7:0]          ctrl_presc;
    logic [7:0]          presc_cnt;
    logic [2:0]          rtc_sync;
    logic                rtc_edge;
    logic                tick;
    reg_sel_t            wsel;
    reg_sel_t            rsel;
    logic                wr_ctrl;
    logic                wr_mtime;
    logic [DATA_WTH-1:0] rd_word;
    logic [DATA_WTH-1:0] rd_data_q;
    logic                rd_vld_q;

    assign wsel     = decode(waddr_i);
    assign rsel     = decode(raddr_i);
    assign wr_ctrl  = wr_en_i && (wsel.kind == SEL_CTRL);
    assign wr_mtime = wr_en_i && (wsel.kind == SEL_MTIME);
    assign rtc_edge = rtc_sync[1] & ~rtc_sync[2];
    assign tick     = rtc_edge && ctrl_en && (presc_cnt == ctrl_presc);
    assign mtime_o  = mtime;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rtc_sync <= '0;
        end else begin
            rtc_sync <= {rtc_sync[1:0], clk_rtc_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl_en    <= 1'b1;
            ctrl_presc <= '0;
            presc_cnt  <= '0;
        end else begin
            if (wr_ctrl) begin
                if (wstrb_i[0]) ctrl_en    <= wdata_i[0];
                if (wstrb_i[1]) ctrl_presc <= wdata_i[15:8];
                presc_cnt <= '0;
            end else if (rtc_edge && ctrl_en) begin
                presc_cnt <= tick ? 8'd0 : presc_cnt + 8'd1;
            end
        end
    end

    // A bus write to either half wins over a same-cycle tick and suppresses the whole increment.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mtime <= '0;
        end else if (wr_mtime) begin
            if (wsel.hi) mtime[63:32] <= merge_bytes(mtime[63:32], wdata_i, wstrb_i);
            else         mtime[31:0]  <= merge_bytes(mtime[31:0],  wdata_i, wstrb_i);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int h = 0; h < HART_NUM; h++) mtimecmp[h] <= '1;
            msip <= '0;
        end else if (wr_en_i) begin
            if (wsel.kind == SEL_CMP) begin
                if (wsel.hi)
                    mtimecmp[wsel.hart][63:32] <= merge_bytes(mtimecmp[wsel.hart][63:32], wdata_i, wstrb_i);
                else
                    mtimecmp[wsel.hart][31:0]  <= merge_bytes(mtimecmp[wsel.hart][31:0], wdata_i, wstrb_i);
            end else if (wsel.kind == SEL_MSIP && wstrb_i[0]) begin
                msip[wsel.hart] <= wdata_i[0];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        case (rsel.kind)
            SEL_MSIP:  rd_word = {{(DATA_WTH-1){1'b0}}, msip[rsel.hart]};
            SEL_CMP:   rd_word = rsel.hi ? mtimecmp[rsel.hart][63:32] : mtimecmp[rsel.hart][31:0];
            SEL_CTRL:  rd_word = {16'h0, ctrl_presc, 7'h0, ctrl_en};
            SEL_MTIME: rd_word = rsel.hi ? mtime[63:32] : mtime[31:0];
            default:   rd_word = '0;
        endcase
    end

    // Data is captured in the request cycle so a colliding write is not visible to the read.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
            rvalid_o  <= 1'b0;
            rdata_o   <= '0;
        end else begin
            rd_vld_q  <= rd_en_i;
            rd_data_q <= rd_en_i ? rd_word : '0;
            rvalid_o  <= rd_vld_q;
            rdata_o   <= rd_vld_q ? rd_data_q : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mtip_o <= '0;
            msip_o <= '0;
        end else begin
            for (int h = 0; h < HART_NUM; h++) mtip_o[h] <= (mtime >= mtimecmp[h]);
            msip_o <= msip;
        end
    end

endmodule

// File: tb/tb_hpu_clint_mh.sv
// Bench for hpu_clint_mh: constant vector table, directed timing sequences,
// and randomized traffic against an address-map level reference model.
module tb_hpu_clint_mh;

    localparam int          H    = 4;
    localparam logic [31:0] BASE = 32'h0200_0000;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          clk_rtc_i = 1'b0;
    logic          wr_en_i = 1'b0;
    logic [31:0]   waddr_i = '0;
    logic [31:0]   wdata_i = '0;
    logic [3:0]    wstrb_i = '0;
    logic          rd_en_i = 1'b0;
    logic [31:0]   raddr_i = '0;
    logic [31:0]   rdata_o;
    logic          rvalid_o;
    logic [H-1:0]  mtip_o;
    logic [H-1:0]  msip_o;
    logic [63:0]   mtime_o;

    hpu_clint_mh #(.HART_NUM(H), .DATA_WTH(32), .ADDR_WTH(32), .BASE_ADDR(BASE)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clk_rtc_i(clk_rtc_i),
        .wr_en_i(wr_en_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .rd_en_i(rd_en_i), .raddr_i(raddr_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
        .mtip_o(mtip_o), .msip_o(msip_o), .mtime_o(mtime_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        step();
        wr_en_i = 1'b1; waddr_i = a; wdata_i = d; wstrb_i = s;
        step();
        wr_en_i = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        int lat;
        d = '0;
        step();
        rd_en_i = 1'b1; raddr_i = a;
        step();
        rd_en_i = 1'b0;
        for (lat = 1; lat <= 10; lat++) begin
            @(negedge clk_i);
            if (rvalid_o) begin
                d = rdata_o;
                break;
            end
        end
        chk("rd_latency", 64'(lat), 64'd2);
        @(negedge clk_i);
        chk("rvalid_pulse", {63'd0, rvalid_o}, 64'd0);
    endtask

    task automatic rtc_pulse();
        step();
        clk_rtc_i = 1'b1;
        repeat (4) step();
        clk_rtc_i = 1'b0;
        repeat (4) step();
    endtask

    // Reference model: register contents as the software-visible address map describes them.
    logic [63:0] m_mtime;
    logic [63:0] m_cmp [H];
    logic [H-1:0] m_msip;
    logic        m_en;
    logic [7:0]  m_presc;
    int          m_cnt;

    task automatic model_reset();
        m_mtime = '0;
        for (int h = 0; h < H; h++) m_cmp[h] = '1;
        m_msip = '0; m_en = 1'b1; m_presc = '0; m_cnt = 0;
    endtask

    function automatic logic [31:0] mmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] off;
        int h;
        off = a - BASE;
        if (off[1:0] != 2'b00) return;
        if (off < 32'(4 * H)) begin
            h = int'(off / 4);
            if (s[0]) m_msip[h] = d[0];
        end else if (off >= 32'h4000 && off < 32'h4000 + 32'(8 * H)) begin
            h = int'((off - 32'h4000) / 8);
            if (((off - 32'h4000) % 8) != 0) m_cmp[h][63:32] = mmerge(m_cmp[h][63:32], d, s);
            else                             m_cmp[h][31:0]  = mmerge(m_cmp[h][31:0], d, s);
        end else if (off == 32'hBFF0) begin
            if (s[0]) m_en = d[0];
            if (s[1]) m_presc = d[15:8];
            m_cnt = 0;
        end else if (off == 32'hBFF8) begin
            m_mtime[31:0] = mmerge(m_mtime[31:0], d, s);
        end else if (off == 32'hBFFC) begin
            m_mtime[63:32] = mmerge(m_mtime[63:32], d, s);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] off;
        int h;
        off = a - BASE;
        if (off[1:0] != 2'b00) return 32'h0;
        if (off < 32'(4 * H)) begin
            h = int'(off / 4);
            return {31'h0, m_msip[h]};
        end
        if (off >= 32'h4000 && off < 32'h4000 + 32'(8 * H)) begin
            h = int'((off - 32'h4000) / 8);
            return (((off - 32'h4000) % 8) != 0) ? m_cmp[h][63:32] : m_cmp[h][31:0];
        end
        if (off == 32'hBFF0) return {16'h0, m_presc, 7'h0, m_en};
        if (off == 32'hBFF8) return m_mtime[31:0];
        if (off == 32'hBFFC) return m_mtime[63:32];
        return 32'h0;
    endfunction

    task automatic model_rtc_edge();
        if (m_en) begin
            if (m_cnt == int'(m_presc)) begin
                m_mtime = m_mtime + 64'd1;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    function automatic logic [H-1:0] exp_mtip();
        logic [H-1:0] r;
        for (int h = 0; h < H; h++) r[h] = (m_mtime >= m_cmp[h]);
        return r;
    endfunction

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic wr, input logic [31:0] off, input logic [31:0] d,
                           input logic [3:0] s, input logic [31:0] e, input string n);
        vec_t v;
        v.wr = wr; v.addr = BASE + off; v.data = d; v.strb = s; v.exp = e; v.name = n;
        tbl.push_back(v);
    endtask

    logic [31:0] offs [22] = '{
        32'h0000, 32'h0004, 32'h0008, 32'h000C, 32'h0010,
        32'h4000, 32'h4004, 32'h4008, 32'h400C, 32'h4010, 32'h4014, 32'h4018, 32'h401C, 32'h4020,
        32'hBFF0, 32'hBFF8, 32'hBFFC, 32'h8000, 32'hBFF4, 32'h0002, 32'h0001_0000, 32'hFFFF_FFFC
    };

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          idx;
        int          op;
        int          seen;
        logic [31:0] off;
        logic [31:0] d;
        logic [3:0]  s;

        // Reset values while held in reset, then after release
        #12;
        chk("rst_rvalid", {63'd0, rvalid_o}, 64'd0);
        chk("rst_rdata", 64'(rdata_o), 64'd0);
        chk("rst_mtime", mtime_o, 64'd0);
        chk("rst_mtip", 64'(mtip_o), 64'd0);
        chk("rst_msip", 64'(msip_o), 64'd0);
        step();
        rst_i = 1'b1;

        add_vec(1'b0, 32'h4000, 32'h0, 4'h0, 32'hFFFF_FFFF, "cmp0_lo_rst");
        add_vec(1'b0, 32'h401C, 32'h0, 4'h0, 32'hFFFF_FFFF, "cmp3_hi_rst");
        add_vec(1'b0, 32'hBFF0, 32'h0, 4'h0, 32'h0000_0001, "ctrl_rst");
        add_vec(1'b0, 32'hBFF8, 32'h0, 4'h0, 32'h0, "mtime_lo_rst");
        add_vec(1'b0, 32'hBFFC, 32'h0, 4'h0, 32'h0, "mtime_hi_rst");
        add_vec(1'b1, 32'h0004, 32'h1, 4'b0010, 32'h0, "");
        add_vec(1'b0, 32'h0004, 32'h0, 4'h0, 32'h0, "msip1_wrong_strb");
        add_vec(1'b1, 32'h0004, 32'h1, 4'b0001, 32'h0, "");
        add_vec(1'b0, 32'h0004, 32'h0, 4'h0, 32'h1, "msip1_set");
        add_vec(1'b1, 32'h0010, 32'h1, 4'hF, 32'h0, "");
        add_vec(1'b0, 32'h0010, 32'h0, 4'h0, 32'h0, "msip_oob");
        add_vec(1'b1, 32'h4008, 32'h1234_5678, 4'b1010, 32'h0, "");
        add_vec(1'b0, 32'h4008, 32'h0, 4'h0, 32'h12FF_56FF, "cmp1_lo_strb");
        add_vec(1'b0, 32'h8000, 32'h0, 4'h0, 32'h0, "unmapped");
        add_vec(1'b0, 32'h0001_0000, 32'h0, 4'h0, 32'h0, "out_of_window");
        add_vec(1'b1, 32'hBFF0, 32'h0000_0301, 4'b0011, 32'h0, "");
        add_vec(1'b0, 32'hBFF0, 32'h0, 4'h0, 32'h0000_0301, "ctrl_presc3");
        add_vec(1'b1, 32'h4020, 32'h0, 4'hF, 32'h0, "");
        add_vec(1'b0, 32'h4000, 32'h0, 4'h0, 32'hFFFF_FFFF, "cmp_oob_ignored");

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].wr) begin
                bus_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
            end else begin
                bus_read(tbl[i].addr, rd);
                chk(tbl[i].name, 64'(rd), 64'(tbl[i].exp));
            end
        end
        repeat (2) step();
        chk("tbl_msip_o", 64'(msip_o), 64'h2);
        chk("tbl_mtip_o", 64'(mtip_o), 64'h0);

        // Prescaler: PRESC=3 gives one tick per four RTC edges; EN=0 freezes
        bus_write(BASE + 32'hBFF0, 32'h0000_0301, 4'hF);
        repeat (8) rtc_pulse();
        chk("presc_mtime", mtime_o, 64'd2);
        bus_read(BASE + 32'hBFF8, rd);
        chk("presc_mtime_rd", 64'(rd), 64'd2);
        bus_write(BASE + 32'hBFF0, 32'h0000_0300, 4'hF);
        repeat (8) rtc_pulse();
        chk("disabled_mtime", mtime_o, 64'd2);

        // Wrap from all-ones to zero
        bus_write(BASE + 32'hBFF0, 32'h0000_0001, 4'hF);
        bus_write(BASE + 32'hBFFC, 32'hFFFF_FFFF, 4'hF);
        bus_write(BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF);
        repeat (2) step();
        chk("wrap_pre_mtime", mtime_o, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wrap_pre_mtip", 64'(mtip_o), 64'hF);
        step();
        clk_rtc_i = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            if (mtime_o == 64'd0) begin seen = 1; break; end
        end
        chk("wrap_seen", 64'(seen), 64'd1);
        chk("wrap_mtip_same", 64'(mtip_o), 64'hF);
        @(negedge clk_i);
        chk("wrap_mtip_next", 64'(mtip_o), 64'h0);
        step();
        clk_rtc_i = 1'b0;
        repeat (4) step();

        // Per-hart compare: only hart 2 fires, one cycle after mtime reaches 0x10
        bus_write(BASE + 32'h4014, 32'h0, 4'hF);
        bus_write(BASE + 32'h4010, 32'h10, 4'hF);
        bus_write(BASE + 32'hBFF8, 32'hF, 4'hF);
        repeat (2) step();
        chk("cmp_pre_mtime", mtime_o, 64'hF);
        chk("cmp_pre_mtip", 64'(mtip_o), 64'h0);
        step();
        clk_rtc_i = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            if (mtime_o == 64'h10) begin seen = 1; break; end
        end
        chk("cmp_seen", 64'(seen), 64'd1);
        chk("cmp_mtip_same", 64'(mtip_o), 64'h0);
        @(negedge clk_i);
        chk("cmp_mtip_next", 64'(mtip_o), 64'h4);
        step();
        clk_rtc_i = 1'b0;
        repeat (4) step();

        // Collision: tick lands two cycles after the RTC rise, same cycle as the write and read
        step();
        clk_rtc_i = 1'b1;
        step();
        step();
        wr_en_i = 1'b1; waddr_i = BASE + 32'hBFF8; wdata_i = 32'h100; wstrb_i = 4'hF;
        rd_en_i = 1'b1; raddr_i = BASE + 32'hBFF8;
        step();
        wr_en_i = 1'b0; rd_en_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("coll_rvalid", {63'd0, rvalid_o}, 64'd1);
        chk("coll_old_rdata", 64'(rdata_o), 64'h10);
        chk("coll_mtime", mtime_o, 64'h100);
        repeat (4) step();
        chk("coll_mtime_hold", mtime_o, 64'h100);
        clk_rtc_i = 1'b0;
        repeat (4) step();

        // Reset with a read in flight
        step();
        rd_en_i = 1'b1; raddr_i = BASE + 32'hBFF8;
        step();
        rd_en_i = 1'b0;
        rst_i = 1'b0;
        #1;
        chk("midrst_rvalid", {63'd0, rvalid_o}, 64'd0);
        chk("midrst_mtime", mtime_o, 64'd0);
        chk("midrst_msip", 64'(msip_o), 64'd0);
        chk("midrst_mtip", 64'(mtip_o), 64'd0);
        step();
        step();
        rst_i = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            if (rvalid_o) seen++;
        end
        chk("midrst_no_rvalid", 64'(seen), 64'd0);
        bus_read(BASE + 32'h4000, rd);
        chk("midrst_cmp0", 64'(rd), 64'hFFFF_FFFF);
        bus_read(BASE + 32'hBFF0, rd);
        chk("midrst_ctrl", 64'(rd), 64'h1);

        // Randomized traffic against the reference model
        model_reset();
        for (int i = 0; i < 200; i++) begin
            op  = $urandom_range(0, 9);
            idx = $urandom_range(0, 21);
            off = offs[idx];
            if (op < 4) begin
                if (off == 32'hBFF0) begin
                    d = {16'h0, 8'($urandom_range(0, 3)), 7'h0, 1'($urandom_range(0, 3) != 0)};
                end else if ((off >= 32'h4000 && off < 32'h4020 && off[2]) || off == 32'hBFFC) begin
                    d = 32'($urandom_range(0, 1));
                end else begin
                    d = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 60)) : 32'($urandom);
                end
                s = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
                bus_write(BASE + off, d, s);
                model_write(BASE + off, d, s);
            end else if (op < 7) begin
                bus_read(BASE + off, rd);
                chk("rnd_rdata", 64'(rd), 64'(model_read(BASE + off)));
            end else begin
                rtc_pulse();
                model_rtc_edge();
            end
            repeat (2) step();
            chk("rnd_mtime", mtime_o, m_mtime);
            chk("rnd_mtip", 64'(mtip_o), 64'(exp_mtip()));
            chk("rnd_msip", 64'(msip_o), 64'(m_msip));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
